ripple_count_monitor: RTL
=========================

# ripple_count_monitor

Synchronous observer for the free-running asynchronous up/down ripple counter. It samples the counter's unsynchronised Q outputs and rejects the ripple transients that occur between flip-flop stages. Each settled value is then decoded into a single-cycle step event with direction, wrap and error flags, plus a signed net-position accumulator. It is the reading end of the ripple counter: the counter drives `cnt_in`, and downstream synchronous logic consumes only this block's outputs.

## Interface
- `WIDTH`, 3: counter width in bits (≥2).
- `STABLE_CYCLES`, 2: consecutive matching synchronised samples required before a value is accepted (≥1).
- `POS_W`, 8: width of the signed net-position accumulator.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cnt_in`  in  WIDTH  raw counter outputs, asynchronous to `clk`.
- `clr`  in  1  synchronous clear of `pos` and `err_cnt`.
- `value`  out  WIDTH  last accepted counter value.
- `ref_valid`  out  1  high once a first value has been accepted.
- `step_valid`  out  1  one-cycle pulse for each legal ±1 step.
- `dir`  out  1  direction of the last legal step (1 = up, 0 = down); holds between steps.
- `wrap`  out  1  one-cycle pulse with `step_valid` on an up step from all-ones to 0 or a down step from 0 to all-ones.
- `err`  out  1  one-cycle pulse when an accepted value differs from `value` by anything other than ±1 mod 2^WIDTH.
- `pos`  out  POS_W  signed net step count.
- `err_cnt`  out  8  count of `err` pulses, saturating at 255.

## Operation
- Synchroniser: two flops per bit (`s1`, `s2`). No logic on `cnt_in` before `s1`.
- Stability filter: candidate register `cand` plus stable counter `stab`, which saturates at STABLE_CYCLES.
  - `s2 != cand`: load `cand <= s2`, `stab <= 1`.
  - Otherwise increment `stab` until it saturates.
  - Accept `cand` on the edge where `stab == STABLE_CYCLES`, `s2 == cand`, and either `cand != value` or the FSM is in INIT.
  - A transient shorter than STABLE_CYCLES synchronised samples is never accepted.
- FSM, 2 states:
  - INIT (reset state): the first acceptance loads `value` and sets `ref_valid`. No `step_valid`, `err` or `pos` change. Go to TRACK.
  - TRACK: on each acceptance with `d = cand - value` mod 2^WIDTH:
    - `d == 1`: `step_valid=1`, `dir=1`, `pos+1`.
    - `d == 2^WIDTH-1`: `step_valid=1`, `dir=0`, `pos-1`.
    - Else: `err=1`, `err_cnt+1` (saturating), `pos` and `dir` unchanged.
    - In every case `value <= cand`, so the reference resyncs after an error.
  - TRACK exits only on reset.
- `pos` wraps in two's complement; no saturation.
- `clr`:
  - Zeroes `pos` and `err_cnt` on the next edge. State, `value` and `dir` are unaffected.
  - If `clr` and a step land on the same edge, `clr` wins: `pos=0`, `err_cnt=0`, but the pulses still fire.
- Reset (`rst_n=0` at an edge) has priority over everything, including mid-filter and mid-step.
  - On reset: `s1`, `s2`, `cand`, `stab`, `value`, `pos` and `err_cnt` go to 0; `ref_valid`, `step_valid`, `dir`, `wrap` and `err` go to 0; FSM goes to INIT.

## Timing
- `cnt_in` stable and first sampled by `s1` at edge k: `s2` at k+1, `cand` at k+2, acceptance and all outputs registered at edge k+2+STABLE_CYCLES. With defaults that is 4 cycles.
- All outputs are registered. `step_valid`, `wrap` and `err` are high for exactly one cycle per acceptance.
- Maximum event rate is one acceptance per STABLE_CYCLES+1 cycles. The source counter must hold each settled value at least STABLE_CYCLES+2 `clk` periods to guarantee detection.
- `step_valid` and `err` are never high in the same cycle. `wrap` implies `step_valid`.

## Test plan
- Reset, then `cnt_in=3'd5` held → `ref_valid=1`, `value=5` at edge 4 after sampling; no `step_valid`, no `err`, `pos=0`.
- From `value=5`, `cnt_in` 6, 7, 0, each held 8 cycles → three `step_valid` pulses, `dir=1`, `wrap` only on the 7→0 step, `pos=3`.
- From `value=0`, step down to 7 then 6 → `wrap` on 0→7, `dir=0`, `pos` decrements by 2. Also cross `pos=-128` down by one and confirm it wraps to 127 (`POS_W=8`).
- Ripple glitch: `value=3`, `cnt_in` 3→2 for 1 cycle, then 4 held → no event for 2; single `step_valid` for 4 with `dir=1`.
- Jump 2→5 → `err` pulse, `value=5`, `err_cnt=1`, `pos` unchanged. A following 5→6 is a legal up step. Drive 300 errors and confirm `err_cnt=255`.
- Assert `rst_n=0` for one edge while `stab=1` with a pending candidate → all outputs 0 and FSM in INIT. Next, assert `clr` on the same edge as a step → `pos=0` and `step_valid=1`.

Source files
------------

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
//   Synchronous observer for a free-running asynchronous up/down ripple
//   counter. The raw counter outputs are double-flopped, filtered so that
//   inter-stage ripple transients are never accepted, and each settled value
//   is decoded into a single-cycle step / wrap / error event plus a signed
//   net-position accumulator.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   cnt_in     in   raw counter outputs, asynchronous to clk
//   clr        in   synchronous clear of pos and err_cnt
//   value      out  last accepted counter value
//   ref_valid  out  high once a first value has been accepted
//   step_valid out  one-cycle pulse per legal +/-1 step
//   dir        out  direction of last legal step (1 = up), held between steps
//   wrap       out  one-cycle pulse with step_valid on a modular wrap
//   err        out  one-cycle pulse on an illegal jump
//   pos        out  signed net step count (wraps, no saturation)
//   err_cnt    out  count of err pulses, saturating at 255
module ripple_count_monitor #(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 2,
  parameter int POS_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        cnt_in,
  input  logic                    clr,
  output logic [WIDTH-1:0]        value,
  output logic                    ref_valid,
  output logic                    step_valid,
  output logic                    dir,
  output logic                    wrap,
  output logic                    err,
  output logic signed [POS_W-1:0] pos,
  output logic [7:0]              err_cnt
);

  localparam int SW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0]    STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             ref_q, ref_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [7:0]       errc_q, errc_d;

  logic             accept;
  logic [WIDTH-1:0] delta;

  always_comb begin
    cand_d  = cand_q;
    stab_d  = stab_q;
    state_d = state_q;
    value_d = value_q;
    ref_d   = ref_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    pos_d   = pos_q;
    errc_d  = errc_q;

    // Stability filter: any change restarts the run length at 1.
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      stab_d = SW'(1);
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + SW'(1);
    end

    // Once accepted, cand == value keeps the saturated filter from
    // re-accepting the same value every cycle (except in INIT).
    accept = (stab_q == STAB_MAX) && (s2_q == cand_q) &&
             ((cand_q != value_q) || (state_q == ST_INIT));
    delta  = cand_q - value_q;

    if (accept) begin
      value_d = cand_q;
      if (state_q == ST_INIT) begin
        ref_d   = 1'b1;
        state_d = ST_TRACK;
      end else if (delta == ONE) begin
        step_d = 1'b1;
        dir_d  = 1'b1;
        wrap_d = (cand_q == '0);
        pos_d  = pos_q + POS_W'(1);
      end else if (delta == ALL_ONES) begin
        step_d = 1'b1;
        dir_d  = 1'b0;
        wrap_d = (cand_q == ALL_ONES);
        pos_d  = pos_q - POS_W'(1);
      end else begin
        err_d = 1'b1;
        if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
      end
    end

    // Clear overrides the accumulators only; event pulses still fire.
    if (clr) begin
      pos_d  = '0;
      errc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      state_q <= ST_INIT;
      value_q <= '0;
      ref_q   <= 1'b0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= '0;
      errc_q  <= '0;
    end else begin
      s1_q    <= cnt_in;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      state_q <= state_d;
      value_q <= value_d;
      ref_q   <= ref_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      pos_q   <= pos_d;
      errc_q  <= errc_d;
    end
  end

  assign value      = value_q;
  assign ref_valid  = ref_q;
  assign step_valid = step_q;
  assign dir        = dir_q;
  assign wrap       = wrap_q;
  assign err        = err_q;
  assign pos        = pos_q;
  assign err_cnt    = errc_q;

endmodule
